sprite_line_eval: RTL and testbench
===================================

# sprite_line_eval

Per-scanline sprite evaluator that sits directly upstream of the per-sprite tile renderers. During each line it scans the 64-entry sprite attribute RAM (OAM) and selects up to 8 sprites whose 8-pixel-tall tile intersects the next game line. It writes them into the inactive bank of a double-buffered sprite view RAM. At the next line start the banks swap, so the renderers read a stable list while the following line is evaluated.

## Interface
- OAM_NUM, 64, OAM entries scanned per line
- VIEW_NUM, 8, sprite slots per line (view RAM depth per bank)
- TILE_H, 8, sprite height in lines
- HIDE_Y, 8'hF0, posY written to unused slots (below the 240-line game area)
- clk  in  1  evaluation clock (faster than pixel clock)
- rstn  in  1  reset, synchronous, active-low
- lineStart  in  1  one-cycle pulse: begin evaluating for nextLineY
- nextLineY  in  8  game-coordinate Y of the line being prepared; sampled on lineStart
- oamAddr  out  6  OAM read address; OAM returns data one cycle later
- oamData  in  32  {posX[31:24], posY[23:16], tileIndex[15:8], hFlip[7], vFlip[6], palette[5:4], rsvd[3:0]}
- viewWe  out  1  view RAM write enable
- viewAddr  out  4  {bank, slot[2:0]}
- viewData  out  32  entry, same format as oamData
- dispBank  out  1  bank the renderers read
- spriteCount  out  4  hits stored for the last completed evaluation (0..8)
- overflow  out  1  more than VIEW_NUM hits on the last completed evaluation
- busy  out  1  evaluation in progress
- late  out  1  one-cycle pulse: lineStart arrived while busy

## Operation
- FSM states: IDLE, SCAN, FILL, DONE.
- IDLE + lineStart: toggle dispBank, latch nextLineY, clear slot counter and hit flag, set oamAddr=0, go to SCAN.
- SCAN: oamAddr increments every cycle, 0..63. Each returned entry is tested one cycle after its address.
  - Hit test: 9-bit diff = {0,lineY} − {0,posY}; hit iff diff[8]==0 and diff[7:0] < TILE_H. There is no wrap-around: posY=250 with line=2 is a miss.
  - Hit with slot<8: write oamData unchanged to {~dispBank, slot}; slot++.
  - Hit with slot==8: set overflow and end scan immediately. No further writes.
  - After entry 63 is tested, or on overflow, go to FILL.
- FILL: write {posX=0, posY=HIDE_Y, others 0} to each slot from slot..7, one per cycle. Skip if slot==8. Then go to DONE.
- DONE: latch spriteCount=slot and overflow, drop busy, return to IDLE.
- lineStart while busy: pulse late and abort. Then perform the IDLE+lineStart action in the same cycle, including the bank toggle and restart. spriteCount and overflow are not updated by the aborted pass.
- OAM entry order is preserved: lower OAM index gets the lower slot.
- All outputs are registered. Reset values: oamAddr=0, viewWe=0, viewAddr=0, viewData=0, dispBank=0, spriteCount=0, overflow=0, busy=0, late=0. State is IDLE.

## Timing
- lineStart at cycle T. At T+1: busy=1, dispBank toggled, oamAddr=0.
- Entry k: address at T+1+k, data at T+2+k. A hit writes (viewWe=1) at T+3+k.
- Full scan with no overflow: last possible scan write at T+66. FILL writes occupy T+67.. for (8−slot) cycles. DONE follows, and busy=0 on the next cycle.
- Worst case is about 76 cycles. It must finish within one line (800 pixel clocks).
- No write ever targets bank dispBank.

## Test plan
- All OAM posY=HIDE_Y, line 100 -> 8 FILL writes to slots 0..7 of bank 1 with posY=F0, spriteCount=0, overflow=0, dispBank=1.
- Hits at OAM 5, 20, 63 (posY=96, line 100) -> writes slots 0,1,2 in index order, with entry 5 write at T+8. Slots 3..7 are filled. spriteCount=3.
- Boundaries at line 100: posY 93 (diff 7) is a hit; posY 92 and 101 are misses. At line 2, posY 250 is a miss.
- 10 hits at OAM 0..9 -> slots 0..7 get entries 0..7, overflow=1, no write for entries 8/9, no FILL writes, spriteCount=8.
- lineStart during SCAN at entry 30 -> late pulses once, dispBank toggles again, scan restarts at oamAddr=0, and prior spriteCount is retained until the new DONE.
- Reset asserted mid-SCAN -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/sprite_line_eval.sv
`default_nettype none
// sprite_line_eval: scans OAM once per line and writes up to VIEW_NUM intersecting
// sprites, then hidden filler entries, into the inactive bank of the view RAM.
module sprite_line_eval #(
  parameter int         OAM_NUM  = 64,
  parameter int         VIEW_NUM = 8,
  parameter int         TILE_H   = 8,
  parameter logic [7:0] HIDE_Y   = 8'hF0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lineStart_i,
  input  logic [7:0]  nextLineY_i,
  output logic [5:0]  oamAddr_o,
  input  logic [31:0] oamData_i,
  output logic        viewWe_o,
  output logic [3:0]  viewAddr_o,
  output logic [31:0] viewData_o,
  output logic        dispBank_o,
  output logic [3:0]  spriteCount_o,
  output logic        overflow_o,
  output logic        busy_o,
  output logic        late_o
);

  localparam logic [5:0] LAST_ADDR = 6'(OAM_NUM - 1);
  localparam logic [3:0] SLOT_FULL = 4'(VIEW_NUM);
  localparam logic [3:0] LAST_SLOT = 4'(VIEW_NUM - 1);
  localparam logic [7:0] TILE_H8   = 8'(TILE_H);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lineY_q, lineY_d;
  logic [3:0]  slot_q, slot_d;
  logic [3:0]  fill_q, fill_d;
  logic        ovf_q, ovf_d;
  logic        pend_q, pend_d;
  logic        pendLast_q, pendLast_d;
  logic [5:0]  oamAddr_q, oamAddr_d;
  logic        viewWe_q, viewWe_d;
  logic [3:0]  viewAddr_q, viewAddr_d;
  logic [31:0] viewData_q, viewData_d;
  logic        dispBank_q, dispBank_d;
  logic [3:0]  spriteCount_q, spriteCount_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic        late_q, late_d;

  logic [8:0]  diff;
  logic        hit;

  // A negative difference (borrow in bit 8) means the sprite starts below the line.
  assign diff = {1'b0, lineY_q} - {1'b0, oamData_i[23:16]};
  assign hit  = ~diff[8] && (diff[7:0] < TILE_H8);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      lineY_q       <= 8'd0;
      slot_q        <= 4'd0;
      fill_q        <= 4'd0;
      ovf_q         <= 1'b0;
      pend_q        <= 1'b0;
      pendLast_q    <= 1'b0;
      oamAddr_q     <= 6'd0;
      viewWe_q      <= 1'b0;
      viewAddr_q    <= 4'd0;
      viewData_q    <= 32'd0;
      dispBank_q    <= 1'b0;
      spriteCount_q <= 4'd0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      late_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lineY_q       <= lineY_d;
      slot_q        <= slot_d;
      fill_q        <= fill_d;
      ovf_q         <= ovf_d;
      pend_q        <= pend_d;
      pendLast_q    <= pendLast_d;
      oamAddr_q     <= oamAddr_d;
      viewWe_q      <= viewWe_d;
      viewAddr_q    <= viewAddr_d;
      viewData_q    <= viewData_d;
      dispBank_q    <= dispBank_d;
      spriteCount_q <= spriteCount_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      late_q        <= late_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lineY_d       = lineY_q;
    slot_d        = slot_q;
    fill_d        = fill_q;
    ovf_d         = ovf_q;
    pend_d        = pend_q;
    pendLast_d    = pendLast_q;
    oamAddr_d     = oamAddr_q;
    viewWe_d      = 1'b0;
    viewAddr_d    = viewAddr_q;
    viewData_d    = viewData_q;
    dispBank_d    = dispBank_q;
    spriteCount_d = spriteCount_q;
    overflow_d    = overflow_q;
    busy_d        = busy_q;
    late_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
      end

      ST_SCAN: begin
        // pend_q marks that oamData_i holds the entry addressed last cycle.
        oamAddr_d  = oamAddr_q + 6'd1;
        pend_d     = 1'b1;
        pendLast_d = (oamAddr_q == LAST_ADDR);
        if (pend_q) begin
          if (hit && (slot_q == SLOT_FULL)) begin
            ovf_d   = 1'b1;
            fill_d  = slot_q;
            state_d = ST_FILL;
          end else begin
            if (hit) begin
              viewWe_d   = 1'b1;
              viewAddr_d = {~dispBank_q, slot_q[2:0]};
              viewData_d = oamData_i;
              slot_d     = slot_q + 4'd1;
            end
            if (pendLast_q) begin
              fill_d  = slot_d;
              state_d = ST_FILL;
            end
          end
        end
      end

      ST_FILL: begin
        if (fill_q == SLOT_FULL) begin
          state_d = ST_DONE;
        end else begin
          viewWe_d   = 1'b1;
          viewAddr_d = {~dispBank_q, fill_q[2:0]};
          viewData_d = {8'h00, HIDE_Y, 16'h0000};
          fill_d     = fill_q + 4'd1;
          if (fill_q == LAST_SLOT) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        spriteCount_d = slot_q;
        overflow_d    = ovf_q;
        busy_d        = 1'b0;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new line always wins. Any write staged this cycle is dropped: after the
    // toggle its bank would be the one the renderers are reading.
    if (lineStart_i) begin
      late_d        = (state_q != ST_IDLE);
      viewWe_d      = 1'b0;
      viewAddr_d    = viewAddr_q;
      viewData_d    = viewData_q;
      spriteCount_d = spriteCount_q;
      overflow_d    = overflow_q;
      dispBank_d    = ~dispBank_q;
      lineY_d       = nextLineY_i;
      slot_d        = 4'd0;
      fill_d        = 4'd0;
      ovf_d         = 1'b0;
      pend_d        = 1'b0;
      pendLast_d    = 1'b0;
      oamAddr_d     = 6'd0;
      busy_d        = 1'b1;
      state_d       = ST_SCAN;
    end
  end

  assign oamAddr_o     = oamAddr_q;
  assign viewWe_o      = viewWe_q;
  assign viewAddr_o    = viewAddr_q;
  assign viewData_o    = viewData_q;
  assign dispBank_o    = dispBank_q;
  assign spriteCount_o = spriteCount_q;
  assign overflow_o    = overflow_q;
  assign busy_o        = busy_q;
  assign late_o        = late_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_eval.sv
`default_nettype none
// Bench for sprite_line_eval: table of single-sprite hit vectors plus hand-written
// multi-hit, overflow, late-abort and mid-scan reset sequences.
module tb_sprite_line_eval;

  localparam logic [31:0] FILL_WORD = 32'h00F0_0000;
  localparam logic [31:0] HID_WORD  = 32'h33F0_4400;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        lineStart = 1'b0;
  logic [7:0]  nextLineY = 8'd0;
  logic [5:0]  oamAddr;
  logic [31:0] oamData = 32'd0;
  logic        viewWe;
  logic [3:0]  viewAddr;
  logic [31:0] viewData;
  logic        dispBank;
  logic [3:0]  spriteCount;
  logic        overflow;
  logic        busy;
  logic        late;

  always #5 clk = ~clk;

  sprite_line_eval dut (
    .clk          (clk),
    .rstn         (rstn),
    .lineStart_i  (lineStart),
    .nextLineY_i  (nextLineY),
    .oamAddr_o    (oamAddr),
    .oamData_i    (oamData),
    .viewWe_o     (viewWe),
    .viewAddr_o   (viewAddr),
    .viewData_o   (viewData),
    .dispBank_o   (dispBank),
    .spriteCount_o(spriteCount),
    .overflow_o   (overflow),
    .busy_o       (busy),
    .late_o       (late)
  );

  // OAM: synchronous read, data one cycle after the address.
  logic [31:0] oam [64];
  always @(posedge clk) oamData <= oam[oamAddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wlog[$];
  int  late_cnt = 0;
  always @(negedge clk) begin
    if (viewWe === 1'b1) wlog.push_back('{c: cyc, a: viewAddr, d: viewData});
    if (late === 1'b1) late_cnt++;
  end

  int   checks = 0;
  int   failures = 0;
  logic exp_disp = 1'b0;
  int   t_start, t_idle;
  wr_t  exp_q[$];
  int   exp_cnt, exp_idle_off;
  logic exp_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] spr(input int idx, input logic [7:0] py);
    return {8'(idx * 3 + 1), py, 8'(idx + 16), 8'hA5};
  endfunction

  task automatic set_hidden();
    for (int k = 0; k < 64; k++) oam[k] = HID_WORD;
  endtask

  // Reference: expected writes (absolute cycle, address, data) for one full pass.
  task automatic build_expect(input logic [7:0] ly, input int t0, input logic bank);
    int slot;
    int py;
    int y;
    slot = 0;
    y = int'(ly);
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_idle_off = 0;
    for (int k = 0; k < 64; k++) begin
      py = int'(oam[k][23:16]);
      if (y >= py && (y - py) < 8) begin
        if (slot == 8) begin
          exp_ovf = 1'b1;
          exp_idle_off = 5 + k;
          break;
        end
        exp_q.push_back('{c: t0 + 3 + k, a: {bank, 3'(slot)}, d: oam[k]});
        slot++;
      end
    end
    if (!exp_ovf) begin
      for (int s = slot; s < 8; s++)
        exp_q.push_back('{c: t0 + 67 + s - slot, a: {bank, 3'(s)}, d: FILL_WORD});
      exp_idle_off = 67 + 8 - slot;
    end
    exp_cnt = slot;
  endtask

  task automatic compare_writes(input string name, input int t0, input int t1);
    wr_t got[$];
    foreach (wlog[i]) if (wlog[i].c > t0 && wlog[i].c <= t1) got.push_back(wlog[i]);
    chk({name, " wrcount"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].c != exp_q[i].c || got[i].a !== exp_q[i].a || got[i].d !== exp_q[i].d) begin
        failures++;
        $display("FAIL %s wr%0d: got off=%0d addr=%h data=%h expected off=%0d addr=%h data=%h",
                 name, i, got[i].c - t0, got[i].a, got[i].d,
                 exp_q[i].c - t0, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic start_line(input logic [7:0] y);
    @(negedge clk);
    nextLineY = y;
    lineStart = 1'b1;
    t_start   = cyc;
    @(negedge clk);
    lineStart = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    t_idle = cyc;
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: busy=%b required 0", name, busy);
    end
  endtask

  // Called at the first negedge after lineStart was sampled.
  task automatic finish_line(input string name, input logic [7:0] y);
    build_expect(y, t_start, ~exp_disp);
    chk({name, " busy"}, 64'(busy), 64'(1'b1));
    chk({name, " dispBank"}, 64'(dispBank), 64'(exp_disp));
    chk({name, " oamAddr0"}, 64'(oamAddr), 64'd0);
    wait_idle(name);
    compare_writes(name, t_start, t_idle);
    chk({name, " doneOff"}, 64'(t_idle - t_start), 64'(exp_idle_off));
    chk({name, " spriteCount"}, 64'(spriteCount), 64'(exp_cnt));
    chk({name, " overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  task automatic eval_line(input string name, input logic [7:0] y);
    start_line(y);
    exp_disp = ~exp_disp;
    finish_line(name, y);
  endtask

  typedef struct {
    logic [7:0] line;
    int         idx;
    logic [7:0] posy;
    logic [3:0] cnt;
  } vec_t;

  vec_t vt[11];

  initial begin : main
    int   n;
    int   late_snap;
    logic seen;

    vt[0]  = '{line: 8'd100, idx: 0,  posy: 8'hF0, cnt: 4'd0};
    vt[1]  = '{line: 8'd100, idx: 1,  posy: 8'd93,  cnt: 4'd1};
    vt[2]  = '{line: 8'd100, idx: 2,  posy: 8'd92,  cnt: 4'd0};
    vt[3]  = '{line: 8'd100, idx: 3,  posy: 8'd101, cnt: 4'd0};
    vt[4]  = '{line: 8'd100, idx: 4,  posy: 8'd100, cnt: 4'd1};
    vt[5]  = '{line: 8'd2,   idx: 5,  posy: 8'd250, cnt: 4'd0};
    vt[6]  = '{line: 8'd100, idx: 63, posy: 8'd96,  cnt: 4'd1};
    vt[7]  = '{line: 8'd0,   idx: 10, posy: 8'd0,   cnt: 4'd1};
    vt[8]  = '{line: 8'd8,   idx: 11, posy: 8'd0,   cnt: 4'd0};
    vt[9]  = '{line: 8'd255, idx: 12, posy: 8'd248, cnt: 4'd1};
    vt[10] = '{line: 8'd255, idx: 13, posy: 8'd247, cnt: 4'd0};

    set_hidden();
    repeat (3) @(negedge clk);
    chk("reset outputs",
        64'({oamAddr, viewWe, viewAddr, viewData, dispBank, spriteCount, overflow, busy, late}),
        64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle busy", 64'(busy), 64'd0);

    for (int v = 0; v < 11; v++) begin
      set_hidden();
      oam[vt[v].idx] = spr(vt[v].idx, vt[v].posy);
      eval_line($sformatf("vec%0d", v), vt[v].line);
      chk($sformatf("vec%0d tableCount", v), 64'(spriteCount), 64'(vt[v].cnt));
    end

    // Three hits keep OAM order; entry 5 lands at T+8 in slot 0.
    set_hidden();
    oam[5]  = spr(5, 8'd96);
    oam[20] = spr(20, 8'd96);
    oam[63] = spr(63, 8'd96);
    eval_line("three", 8'd100);
    seen = 1'b0;
    foreach (wlog[i]) begin
      if (!seen && wlog[i].c > t_start) begin
        seen = 1'b1;
        chk("three firstOff", 64'(wlog[i].c - t_start), 64'd8);
        chk("three firstAddr", 64'(wlog[i].a), 64'({~exp_disp, 3'd0}));
      end
    end
    chk("three count", 64'(spriteCount), 64'd3);

    // Ten hits: eight stored, overflow ends the scan with no filler.
    set_hidden();
    for (int k = 0; k < 10; k++) oam[k] = spr(k, 8'd100);
    eval_line("ovf", 8'd103);
    chk("ovf count", 64'(spriteCount), 64'd8);
    chk("ovf flag", 64'(overflow), 64'd1);
    chk("ovf idleOff", 64'(t_idle - t_start), 64'd13);

    // lineStart mid-scan: late pulse, restart, old results held.
    set_hidden();
    oam[2]  = spr(2, 8'd45);
    oam[40] = spr(40, 8'd45);
    late_snap = late_cnt;
    start_line(8'd50);
    exp_disp = ~exp_disp;
    n = 0;
    while (oamAddr !== 6'd29 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort reach29", 64'(oamAddr), 64'd29);
    start_line(8'd50);
    exp_disp = ~exp_disp;
    chk("abort late", 64'(late), 64'd1);
    chk("abort keepCount", 64'(spriteCount), 64'd8);
    chk("abort keepOvf", 64'(overflow), 64'd1);
    finish_line("abort", 8'd50);
    chk("abort lateOnce", 64'(late_cnt - late_snap), 64'd1);

    // Reset in the middle of a scan.
    set_hidden();
    oam[5] = spr(5, 8'd96);
    start_line(8'd100);
    exp_disp = ~exp_disp;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset outputs",
        64'({oamAddr, viewWe, viewAddr, viewData, dispBank, spriteCount, overflow, busy, late}),
        64'd0);
    rstn = 1'b1;
    exp_disp = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset idle", 64'(busy), 64'd0);
    eval_line("postreset", 8'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
